// File: rtl/audio_fir_stage.sv
// Stereo FIR stage placed between the codec read and write sides.
// Each channel uses one MAC per cycle over TAPS cycles. The rounded result is held until the codec takes it.
// With FIR_SATURATE_EN defined, the narrowed output clamps; otherwise it wraps.
module audio_fir_stage #(
    parameter int TAPS   = 16,
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 15
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     read_ready,
    input  logic signed [DATA_W-1:0] readdata_left,
    input  logic signed [DATA_W-1:0] readdata_right,
    output logic                     read,
    input  logic                     write_ready,
    output logic                     write,
    output logic signed [DATA_W-1:0] writedata_left,
    output logic signed [DATA_W-1:0] writedata_right,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy
);

    localparam int AW    = $clog2(TAPS);
    // One extra coefficient bit so that +1.0 (the reset identity tap) is representable.
    localparam int CW    = COEF_W + 1;
    localparam int PW    = DATA_W + CW;
    localparam int ACC_W = DATA_W + COEF_W + AW;
    localparam int RW    = ACC_W - SHIFT + 1;

    localparam logic [AW-1:0]        LAST       = AW'(TAPS - 1);
    localparam logic signed [CW-1:0] COEF_ONE   = CW'(1) << SHIFT;
    localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W + 1)'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]             idx;
    logic                      out_valid;
    logic signed [DATA_W-1:0]  delay_left  [TAPS];
    logic signed [DATA_W-1:0]  delay_right [TAPS];
    logic signed [CW-1:0]      coef        [TAPS];
    logic signed [ACC_W-1:0]   acc_left;
    logic signed [ACC_W-1:0]   acc_right;
    logic signed [PW-1:0]      prod_left;
    logic signed [PW-1:0]      prod_right;

    function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = (ACC_W + 1)'(a) + ROUND_HALF;
        return t[ACC_W:SHIFT];
    endfunction

    function automatic logic signed [DATA_W-1:0] narrow(input logic signed [RW-1:0] r);
`ifdef FIR_SATURATE_EN
        if (r[RW-1:DATA_W-1] == '0 || r[RW-1:DATA_W-1] == '1)
            return r[DATA_W-1:0];
        else if (r[RW-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
`else
        return r[DATA_W-1:0];
`endif
    endfunction

    assign prod_left  = PW'(delay_left[idx])  * PW'(coef[idx]);
    assign prod_right = PW'(delay_right[idx]) * PW'(coef[idx]);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A held output that is being written this cycle frees the slot for the next read.
    always_comb begin
        state_next = state;
        write      = out_valid && write_ready;
        read       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (read_ready && (!out_valid || write)) begin
                    read       = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (idx == LAST)
                    state_next = ROUND;
            end
            ROUND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx             <= '0;
            acc_left        <= '0;
            acc_right       <= '0;
            out_valid       <= 1'b0;
            writedata_left  <= '0;
            writedata_right <= '0;
            for (int i = 0; i < TAPS; i++) begin
                delay_left[i]  <= '0;
                delay_right[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (read) begin
                        delay_left[0]  <= readdata_left;
                        delay_right[0] <= readdata_right;
                        for (int i = 1; i < TAPS; i++) begin
                            delay_left[i]  <= delay_left[i-1];
                            delay_right[i] <= delay_right[i-1];
                        end
                        acc_left  <= '0;
                        acc_right <= '0;
                        idx       <= '0;
                    end
                end
                MAC: begin
                    acc_left  <= acc_left  + ACC_W'(prod_left);
                    acc_right <= acc_right + ACC_W'(prod_right);
                    if (idx != LAST)
                        idx <= idx + 1'b1;
                end
                ROUND: begin
                    writedata_left  <= narrow(round_shift(acc_left));
                    writedata_right <= narrow(round_shift(acc_right));
                end
                default: begin
                end
            endcase

            if (state == ROUND)
                out_valid <= 1'b1;
            else if (write)
                out_valid <= 1'b0;
        end
    end

    // Coefficients change only between samples, never under a running MAC.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++)
                coef[i] <= (i == 0) ? COEF_ONE : '0;
        end else if (coef_we && state == IDLE && 32'(coef_addr) < TAPS) begin
            coef[coef_addr] <= CW'(coef_data);
        end
    end

endmodule
